// File: rtl/eprisc_mem_initiator.sv
// Bus initiator between the epRISC core and the on-chip synchronous RAM/ROM.
// Single-beat writes and burst reads with registered outputs throughout.
module eprisc_mem_initiator #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int LEN_W     = 5
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic              iReqWrite,
  input  logic              iReqRom,
  input  logic [ADDR_W-1:0] iReqAddr,
  input  logic [DATA_W-1:0] iReqData,
  input  logic [LEN_W-1:0]  iReqLen,
  output logic              oRspValid,
  output logic [DATA_W-1:0] oRspData,
  output logic              oRspLast,
  output logic              oRspErr,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  output logic              oRamWrite,
  output logic              oRomEnable,
  input  logic [DATA_W-1:0] iRamData,
  input  logic [DATA_W-1:0] iRomData
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, TAIL, ACK} tState;

  localparam logic [LEN_W-1:0] cBurstMax = LEN_W'(BURST_MAX);

  tState             state, stateNxt;
  logic              isRom, isRomNxt;
  logic [LEN_W-1:0]  lastIdx, lastIdxNxt;
  logic [LEN_W-1:0]  issueCnt, issueCntNxt;
  logic              capValid, capValidNxt;
  logic              capLast, capLastNxt;
  logic              reqReadyNxt, rspValidNxt, rspLastNxt, rspErrNxt;
  logic              ramWriteNxt, romEnableNxt;
  logic [DATA_W-1:0] rspDataNxt, memDataNxt;
  logic [ADDR_W-1:0] memAddrNxt;
  logic [LEN_W-1:0]  effLastIdx;

  // Index of the final beat: length 0 behaves as 1, oversize lengths clamp.
  always_comb begin
    if (iReqLen == '0)
      effLastIdx = '0;
    else if (iReqLen > cBurstMax)
      effLastIdx = cBurstMax - 1'b1;
    else
      effLastIdx = iReqLen - 1'b1;
  end

  // NOTE: every signal gets its default before the case so no latch is inferred.
  always_comb begin
    stateNxt     = state;
    isRomNxt     = isRom;
    lastIdxNxt   = lastIdx;
    issueCntNxt  = issueCnt;
    reqReadyNxt  = 1'b0;
    memAddrNxt   = oMemAddr;
    memDataNxt   = oMemData;
    ramWriteNxt  = 1'b0;
    romEnableNxt = oRomEnable;
    // Capture pipeline: address in cycle C, data in C+1, beat in C+2.
    capValidNxt  = (state == READ);
    capLastNxt   = (state == READ) && (issueCnt == lastIdx);
    rspValidNxt  = capValid;
    rspLastNxt   = capValid && capLast;
    rspErrNxt    = 1'b0;
    rspDataNxt   = '0;
    if (capValid)
      rspDataNxt = isRom ? iRomData : iRamData;

    unique case (state)
      IDLE: begin
        if (oReqReady && iReqValid) begin
          isRomNxt   = iReqRom;
          memAddrNxt = iReqAddr;
          if (iReqWrite) begin
            memDataNxt  = iReqData;
            ramWriteNxt = !iReqRom;
            stateNxt    = WRITE;
          end else begin
            lastIdxNxt   = effLastIdx;
            issueCntNxt  = '0;
            romEnableNxt = iReqRom;
            stateNxt     = READ;
          end
        end else begin
          reqReadyNxt = 1'b1;
        end
      end
      WRITE: begin
        rspValidNxt = 1'b1;
        rspLastNxt  = 1'b1;
        rspErrNxt   = isRom;
        stateNxt    = ACK;
      end
      READ: begin
        if (issueCnt == lastIdx) begin
          stateNxt = TAIL;
        end else begin
          memAddrNxt  = oMemAddr + 1'b1;
          issueCntNxt = issueCnt + 1'b1;
        end
      end
      TAIL: begin
        romEnableNxt = 1'b0;
        stateNxt     = ACK;
      end
      ACK: begin
        reqReadyNxt = 1'b1;
        stateNxt    = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state      <= IDLE;
      isRom      <= 1'b0;
      lastIdx    <= '0;
      issueCnt   <= '0;
      capValid   <= 1'b0;
      capLast    <= 1'b0;
      oReqReady  <= 1'b0;
      oRspValid  <= 1'b0;
      oRspData   <= '0;
      oRspLast   <= 1'b0;
      oRspErr    <= 1'b0;
      oMemAddr   <= '0;
      oMemData   <= '0;
      oRamWrite  <= 1'b0;
      oRomEnable <= 1'b0;
    end else begin
      state      <= stateNxt;
      isRom      <= isRomNxt;
      lastIdx    <= lastIdxNxt;
      issueCnt   <= issueCntNxt;
      capValid   <= capValidNxt;
      capLast    <= capLastNxt;
      oReqReady  <= reqReadyNxt;
      oRspValid  <= rspValidNxt;
      oRspData   <= rspDataNxt;
      oRspLast   <= rspLastNxt;
      oRspErr    <= rspErrNxt;
      oMemAddr   <= memAddrNxt;
      oMemData   <= memDataNxt;
      oRamWrite  <= ramWriteNxt;
      oRomEnable <= romEnableNxt;
    end
  end

endmodule

// File: tb/tb_eprisc_mem_initiator.sv
// Directed bench for eprisc_mem_initiator with behavioural RAM and ROM models.
module tb_eprisc_mem_initiator;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;

  logic              iClk = 1'b0;
  logic              iReset = 1'b1;
  logic              iReqValid = 1'b0;
  logic              oReqReady;
  logic              iReqWrite = 1'b0;
  logic              iReqRom = 1'b0;
  logic [ADDR_W-1:0] iReqAddr = '0;
  logic [DATA_W-1:0] iReqData = '0;
  logic [LEN_W-1:0]  iReqLen = '0;
  logic              oRspValid;
  logic [DATA_W-1:0] oRspData;
  logic              oRspLast;
  logic              oRspErr;
  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] oMemData;
  logic              oRamWrite;
  logic              oRomEnable;
  logic [DATA_W-1:0] iRamData;
  logic [DATA_W-1:0] iRomData;

  eprisc_mem_initiator dut (
    .iClk(iClk), .iReset(iReset),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWrite(iReqWrite),
    .iReqRom(iReqRom), .iReqAddr(iReqAddr), .iReqData(iReqData), .iReqLen(iReqLen),
    .oRspValid(oRspValid), .oRspData(oRspData), .oRspLast(oRspLast), .oRspErr(oRspErr),
    .oMemAddr(oMemAddr), .oMemData(oMemData), .oRamWrite(oRamWrite),
    .oRomEnable(oRomEnable), .iRamData(iRamData), .iRomData(iRomData)
  );

  always #5 iClk = ~iClk;

  // Synchronous memories: one-clock registered read; ROM reads 0 when disabled.
  logic [DATA_W-1:0] ram [1024];
  logic [DATA_W-1:0] rom [1024];
  logic [DATA_W-1:0] ramQ = '0;
  logic [DATA_W-1:0] romQ = '0;
  always @(posedge iClk) begin
    if (oRamWrite) ram[oMemAddr] <= oMemData;
    ramQ <= ram[oMemAddr];
    romQ <= rom[oMemAddr];
  end
  assign iRamData = ramQ;
  assign iRomData = oRomEnable ? romQ : '0;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] beatData [$];
  logic              beatLast [$];
  logic              beatErr  [$];
  int firstBeat, lastBeat, romCycles, ramWrites, readyCycle, strayValid;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Returns one cycle after the acceptance edge.
  task automatic sendReq(input logic wr, input logic rom, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [LEN_W-1:0] len);
    bit done = 0;
    iReqValid = 1'b1; iReqWrite = wr; iReqRom = rom;
    iReqAddr = addr; iReqData = data; iReqLen = len;
    for (int i = 0; i < 20 && !done; i++) begin
      if (oReqReady) done = 1;
      tick();
    end
    iReqValid = 1'b0;
    iReqData = '1;
    iReqAddr = '1;
    check("accept", 32'(done), 32'd1);
  endtask

  // Cycle 1 is the cycle after acceptance; logs beats until oReqReady returns.
  task automatic runTxn(input logic wr, input logic rom, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [LEN_W-1:0] len);
    beatData.delete(); beatLast.delete(); beatErr.delete();
    firstBeat = 0; lastBeat = 0; romCycles = 0; ramWrites = 0; readyCycle = 0;
    wrAddr = '0; wrData = '0;
    sendReq(wr, rom, addr, data, len);
    for (int c = 1; c <= 40; c++) begin
      if (oRspValid) begin
        if (firstBeat == 0) firstBeat = c;
        lastBeat = c;
        beatData.push_back(oRspData);
        beatLast.push_back(oRspLast);
        beatErr.push_back(oRspErr);
      end
      if (oRomEnable) romCycles++;
      if (oRamWrite) begin
        ramWrites++;
        wrAddr = oMemAddr;
        wrData = oMemData;
      end
      if (oReqReady) begin
        readyCycle = c;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [31:0] allOuts();
    return {oReqReady, oRspValid, oRspLast, oRspErr, oRamWrite, oRomEnable} |
           32'(oRspData) | 32'(oMemAddr) | 32'(oMemData);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'hA000_0000 | 32'(i);
      rom[i] = 32'h1000_0000 + 32'(i);
    end

    // Reset held while the core is requesting.
    iReqValid = 1'b1; iReqWrite = 1'b1; iReqAddr = 10'h123; iReqData = 32'h5555_AAAA;
    tick(); tick();
    check("rst_outputs", allOuts(), 32'd0);
    iReqValid = 1'b0;
    iReset = 1'b0;
    #1;
    check("rst_ready_low", 32'(oReqReady), 32'd0);
    tick();
    check("rst_ready_rise", 32'(oReqReady), 32'd1);

    // RAM write.
    runTxn(1'b1, 1'b0, 10'h005, 32'hDEADBEEF, 5'd0);
    check("wr_strobes", 32'(ramWrites), 32'd1);
    check("wr_addr", 32'(wrAddr), 32'h005);
    check("wr_data", wrData, 32'hDEADBEEF);
    check("wr_beats", 32'(beatData.size()), 32'd1);
    check("wr_ack_cycle", 32'(firstBeat), 32'd2);
    check("wr_ack_data", beatData[0], 32'd0);
    check("wr_ack_last", 32'(beatLast[0]), 32'd1);
    check("wr_ack_err", 32'(beatErr[0]), 32'd0);
    check("wr_ready_cycle", 32'(readyCycle), 32'd3);

    // RAM read-back, single beat.
    runTxn(1'b0, 1'b0, 10'h005, 32'd0, 5'd1);
    check("rd1_beats", 32'(beatData.size()), 32'd1);
    check("rd1_first", 32'(firstBeat), 32'd3);
    check("rd1_data", beatData[0], 32'hDEADBEEF);
    check("rd1_last", 32'(beatLast[0]), 32'd1);
    check("rd1_ready_cycle", 32'(readyCycle), 32'd4);

    // ROM burst of 4.
    runTxn(1'b0, 1'b1, 10'h000, 32'd0, 5'd4);
    check("rom_beats", 32'(beatData.size()), 32'd4);
    check("rom_first", 32'(firstBeat), 32'd3);
    check("rom_lastcyc", 32'(lastBeat), 32'd6);
    check("rom_enable_cycles", 32'(romCycles), 32'd5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rom_data%0d", i), beatData[i], 32'h1000_0000 + 32'(i));
      check($sformatf("rom_last%0d", i), 32'(beatLast[i]), 32'(i == 3));
      check($sformatf("rom_err%0d", i), 32'(beatErr[i]), 32'd0);
    end
    check("rom_ready_cycle", 32'(readyCycle), 32'd7);

    // Address wrap at the top of the RAM.
    runTxn(1'b0, 1'b0, 10'h3FE, 32'd0, 5'd3);
    check("wrap_beats", 32'(beatData.size()), 32'd3);
    check("wrap_d0", beatData[0], 32'hA000_03FE);
    check("wrap_d1", beatData[1], 32'hA000_03FF);
    check("wrap_d2", beatData[2], 32'hA000_0000);
    check("wrap_rom_en", 32'(romCycles), 32'd0);

    // Length 0 behaves as 1.
    runTxn(1'b0, 1'b0, 10'h040, 32'd0, 5'd0);
    check("len0_beats", 32'(beatData.size()), 32'd1);
    check("len0_data", beatData[0], 32'hA000_0040);
    check("len0_last", 32'(beatLast[0]), 32'd1);

    // Length 31 clamps to 16.
    runTxn(1'b0, 1'b0, 10'h100, 32'd0, 5'd31);
    check("len31_beats", 32'(beatData.size()), 32'd16);
    check("len31_span", 32'(lastBeat - firstBeat), 32'd15);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("len31_data%0d", i), beatData[i], 32'hA000_0100 + 32'(i));
      check($sformatf("len31_last%0d", i), 32'(beatLast[i]), 32'(i == 15));
    end
    check("len31_ready_cycle", 32'(readyCycle), 32'd19);

    // Write to ROM region is dropped and flagged.
    runTxn(1'b1, 1'b1, 10'h005, 32'h1234_5678, 5'd0);
    check("romwr_strobes", 32'(ramWrites), 32'd0);
    check("romwr_beats", 32'(beatData.size()), 32'd1);
    check("romwr_err", 32'(beatErr[0]), 32'd1);
    check("romwr_last", 32'(beatLast[0]), 32'd1);
    check("romwr_data", beatData[0], 32'd0);
    runTxn(1'b0, 1'b0, 10'h005, 32'd0, 5'd1);
    check("romwr_ram_intact", beatData[0], 32'hDEADBEEF);

    // Reset after the second beat of an 8-beat read.
    sendReq(1'b0, 1'b0, 10'h010, 32'd0, 5'd8);
    tick(); tick();
    check("mid_beat1", oRspData, 32'hA000_0010);
    tick();
    check("mid_beat2", oRspData, 32'hA000_0011);
    iReset = 1'b1;
    #1;
    check("mid_rst_outputs", allOuts(), 32'd0);
    strayValid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (oRspValid) strayValid++;
    end
    iReset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (oRspValid) strayValid++;
      if (i == 0) check("mid_ready_low", 32'(oReqReady), 32'd0);
      tick();
      if (i == 0) check("mid_ready_rise", 32'(oReqReady), 32'd1);
    end
    check("mid_no_stray_beats", 32'(strayValid), 32'd0);
    runTxn(1'b0, 1'b0, 10'h020, 32'd0, 5'd2);
    check("post_beats", 32'(beatData.size()), 32'd2);
    check("post_d0", beatData[0], 32'hA000_0020);
    check("post_d1", beatData[1], 32'hA000_0021);
    check("post_last", 32'(beatLast[1]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
